ir_adc_scheduler: RTL

//   Periodically sequences N IR range sensors through one shared ADC DRP read port and one shared

---
 rtl/wall_follower_pkg.sv | 15 +
 rtl/tick_divider.sv | 34 +++
 rtl/ir_adc_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wall_follower_pkg.sv
// Shared widths and scheduler state type for the IR range-sensor front end.
package wall_follower_pkg;

  localparam int unsigned ADC_W      = 16;
  localparam int unsigned DIST_W     = 7;
  localparam int unsigned DRP_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    LUT
  } sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running period counter; emits a one-cycle tick at count DIV-1 and is held at 0
// while disabled.
module tick_divider #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/ir_adc_scheduler.sv
// Sequences NUM_CH IR sensors through a shared DRP read port and a shared registered
// ADC->distance LUT once per sample period, holding the latest distance per channel.
module ir_adc_scheduler
  import wall_follower_pkg::*;
#(
  parameter int unsigned            NUM_CH       = 4,
  parameter int unsigned            SAMPLE_DIV   = 100000,
  parameter logic [DRP_ADDR_W-1:0]  CH_ADDR_BASE = 7'h10,
  parameter int unsigned            DRP_TIMEOUT  = 255,
  parameter int unsigned            LUT_LAT      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear_err,
  output logic                     drp_den,
  output logic [DRP_ADDR_W-1:0]    drp_daddr,
  input  logic                     drp_drdy,
  input  logic [ADC_W-1:0]         drp_do,
  output logic [ADC_W-1:0]         lut_adc_data,
  input  logic [DIST_W-1:0]        lut_distance_cm,
  output logic [DIST_W*NUM_CH-1:0] distance_cm,
  output logic [NUM_CH-1:0]        dist_valid,
  output logic                     frame_done,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic                     overrun
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TMO_W = $clog2(DRP_TIMEOUT + 1);
  localparam int unsigned LC_W  = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRP_TIMEOUT - 1);
  localparam logic [LC_W-1:0]  LUT_LAST = LC_W'(LUT_LAT);

  sched_state_t             state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [LC_W-1:0]          lut_cnt_q, lut_cnt_d;
  logic [ADC_W-1:0]         adc_q, adc_d;
  logic [DIST_W*NUM_CH-1:0] dist_q, dist_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH-1:0]        terr_q, terr_d;
  logic                     overrun_q, overrun_d;
  logic                     frame_done_q, frame_done_d;
  logic                     advance;
  logic                     tick;

  tick_divider #(
    .DIV (SAMPLE_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tmo_d        = tmo_q;
    lut_cnt_d    = lut_cnt_q;
    adc_d        = adc_q;
    dist_d       = dist_q;
    valid_d      = valid_q;
    terr_d       = terr_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;

    // Clear first so a coincident new error still lands.
    if (clear_err) begin
      terr_d    = '0;
      overrun_d = 1'b0;
    end
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          ch_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (drp_drdy) begin
          adc_d     = drp_do;
          lut_cnt_d = '0;
          state_d   = LUT;
        end else if (tmo_q == TMO_LAST) begin
          terr_d[ch_q] = 1'b1;
          advance      = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      LUT: begin
        if (lut_cnt_q == LUT_LAST) begin
          dist_d[ch_q*DIST_W +: DIST_W] = lut_distance_cm;
          valid_d[ch_q]                 = 1'b1;
          advance                       = 1'b1;
        end else begin
          lut_cnt_d = lut_cnt_q + LC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing enable lets the current channel finish, then parks without a frame pulse.
    if (advance) begin
      if (!enable) begin
        state_d = IDLE;
      end else if (ch_q == LAST_CH) begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      tmo_q        <= '0;
      lut_cnt_q    <= '0;
      adc_q        <= '0;
      dist_q       <= '0;
      valid_q      <= '0;
      terr_q       <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      tmo_q        <= tmo_d;
      lut_cnt_q    <= lut_cnt_d;
      adc_q        <= adc_d;
      dist_q       <= dist_d;
      valid_q      <= valid_d;
      terr_q       <= terr_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign drp_den      = (state_q == REQ);
  assign drp_daddr    = CH_ADDR_BASE + DRP_ADDR_W'(ch_q);
  assign lut_adc_data = adc_q;
  assign distance_cm  = dist_q;
  assign dist_valid   = valid_q;
  assign timeout_err  = terr_q;
  assign overrun      = overrun_q;
  assign frame_done   = frame_done_q;

endmodule
